// File: rtl/encoder83_reg.sv
`default_nettype none
// ============================================================================
// Module      : encoder83_reg
// Description : Registered 8-to-3 priority encoder with sticky request capture
//               and a valid/ready output; fixed or round-robin priority.
// Revision    : 1.0 - initial release
// ============================================================================
module encoder83_reg #(
    parameter int N        = 8,
    parameter int W        = 3,
    parameter int RR       = 0,
    parameter int HI_FIRST = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    output logic [W-1:0] code,
    output logic         valid,
    input  logic         ready,
    output logic [N-1:0] pending
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   code_q, code_d;
    logic [W-1:0]   ptr_q, ptr_d;
    logic [N-1:0]   pending_q, pending_d;
    logic [N-1:0]   clr, elig;
    logic [W-1:0]   sel, idx;
    logic           accept, load;

    always_comb begin
        accept    = (state_q == HOLD) && ready;
        clr       = accept ? (N'(1) << code_q) : '0;
        // A request arriving on the line being acknowledged re-arms it.
        pending_d = (pending_q | req) & ~(clr & ~req);
        elig      = pending_d & mask;
        ptr_d     = accept ? code_q + W'(1) : ptr_q;

        sel = '0;
        idx = '0;
        if (RR != 0) begin
            // Walk down from the farthest offset so the nearest hit above ptr wins.
            for (int k = N - 1; k >= 0; k--) begin
                idx = ptr_d + k[W-1:0];
                if (elig[idx]) sel = idx;
            end
        end else if (HI_FIRST != 0) begin
            for (int i = 0; i < N; i++) begin
                if (elig[i]) sel = i[W-1:0];
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (elig[i]) sel = i[W-1:0];
            end
        end

        load    = (state_q == IDLE) || accept;
        state_d = state_q;
        code_d  = code_q;
        if (load) begin
            state_d = (|elig) ? HOLD : IDLE;
            code_d  = sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            code_q    <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            pending_q <= pending_d;
        end
    end

    generate
        if (RR != 0) begin : g_rr_ptr
            always_ff @(posedge clk or posedge rst) begin
                if (rst) ptr_q <= '0;
                else     ptr_q <= ptr_d;
            end
        end else begin : g_fixed_ptr
            assign ptr_q = '0;
        end
    endgenerate

    assign code    = code_q;
    assign valid   = (state_q == HOLD);
    assign pending = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_encoder83_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_encoder83_reg
// Description : Scoreboard bench for encoder83_reg in three priority modes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder83_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req, mask;
    logic       ready;

    logic [2:0] d_code  [3];
    logic       d_valid [3];
    logic [7:0] d_pend  [3];

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        logic       v [3];
        logic [2:0] c [3];
        logic [7:0] p [3];
    } snap_t;

    snap_t sb_q[$];

    // Reference state: instance 0 fixed hi-first, 1 fixed lo-first, 2 round-robin
    int         m_code [3];
    int         m_ptr  [3];
    bit         m_v    [3];
    logic [7:0] m_pend [3];

    always #5 clk = ~clk;

    encoder83_reg #(.N(8), .W(3), .RR(0), .HI_FIRST(1)) u_fix_hi (
        .clk(clk), .rst(rst), .req(req), .mask(mask), .code(d_code[0]),
        .valid(d_valid[0]), .ready(ready), .pending(d_pend[0]));

    encoder83_reg #(.N(8), .W(3), .RR(0), .HI_FIRST(0)) u_fix_lo (
        .clk(clk), .rst(rst), .req(req), .mask(mask), .code(d_code[1]),
        .valid(d_valid[1]), .ready(ready), .pending(d_pend[1]));

    encoder83_reg #(.N(8), .W(3), .RR(1), .HI_FIRST(1)) u_rr (
        .clk(clk), .rst(rst), .req(req), .mask(mask), .code(d_code[2]),
        .valid(d_valid[2]), .ready(ready), .pending(d_pend[2]));

    function automatic int pick(int inst, int ptr, logic [7:0] e);
        if (inst == 2) begin
            for (int k = 0; k < 8; k++)
                if (e[(ptr + k) % 8]) return (ptr + k) % 8;
        end else if (inst == 0) begin
            for (int i = 7; i >= 0; i--) if (e[i]) return i;
        end else begin
            for (int i = 0; i < 8; i++) if (e[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_code[i] = 0;
            m_ptr[i]  = 0;
            m_v[i]    = 1'b0;
            m_pend[i] = 8'h00;
        end
    endtask

    task automatic model_edge();
        snap_t s;
        for (int i = 0; i < 3; i++) begin
            bit         acc;
            logic [7:0] np, e;
            acc = m_v[i] && ready;
            np  = m_pend[i] | req;
            if (acc) begin
                if (!req[m_code[i]]) np[m_code[i]] = 1'b0;
                m_ptr[i] = (m_code[i] + 1) % 8;
            end
            m_pend[i] = np;
            if (!m_v[i] || acc) begin
                e         = np & mask;
                m_v[i]    = (e != 8'h00);
                m_code[i] = (e != 8'h00) ? pick(i, m_ptr[i], e) : 0;
            end
            s.v[i] = m_v[i];
            s.c[i] = m_code[i][2:0];
            s.p[i] = m_pend[i];
        end
        sb_q.push_back(s);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Apply one clock of stimulus; returns just after the edge.
    task automatic step(input logic [7:0] r, input logic [7:0] m, input logic rd);
        req   = r;
        mask  = m;
        ready = rd;
        @(posedge clk);
        model_edge();
        #1;
        vectors++;
    endtask

    task automatic drain();
        for (int i = 0; i < 10; i++) step(8'h00, 8'hFF, 1'b1);
    endtask

    // Monitor: each cycle the DUTs present registered outputs, compare against the queue.
    always @(negedge clk) begin
        if (!rst && sb_q.size() > 0) begin
            snap_t e;
            e = sb_q.pop_front();
            for (int i = 0; i < 3; i++) begin
                if (d_valid[i] !== e.v[i]) begin
                    miscompares++;
                    $display("FAIL sb_valid[%0d] actual=%0b required=%0b", i, d_valid[i], e.v[i]);
                end
                if (e.v[i] && d_code[i] !== e.c[i]) begin
                    miscompares++;
                    $display("FAIL sb_code[%0d] actual=%0d required=%0d", i, d_code[i], e.c[i]);
                end
                if (d_pend[i] !== e.p[i]) begin
                    miscompares++;
                    $display("FAIL sb_pending[%0d] actual=%h required=%h", i, d_pend[i], e.p[i]);
                end
            end
        end
    end

    initial begin
        rst   = 1'b1;
        req   = 8'h00;
        mask  = 8'hFF;
        ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_valid", int'(d_valid[i]), 0);
            chk("reset_code", int'(d_code[i]), 0);
            chk("reset_pending", int'(d_pend[i]), 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // Round-robin sweep from ptr=0, then wrap behaviour with 8'h81
        step(8'hFF, 8'hFF, 1'b1);
        chk("rr_first", int'(d_code[2]), 0);
        for (int k = 1; k < 8; k++) begin
            step(8'h00, 8'hFF, 1'b1);
            chk("rr_seq", int'(d_code[2]), k);
        end
        step(8'h81, 8'hFF, 1'b1);
        chk("rr_wrap0", int'(d_code[2]), 0);
        step(8'h00, 8'hFF, 1'b1);
        chk("rr_wrap7", int'(d_code[2]), 7);
        drain();

        // Two simultaneous requests, hi-first
        step(8'h24, 8'hFF, 1'b1);
        chk("t1_code5", int'(d_code[0]), 5);
        step(8'h00, 8'hFF, 1'b1);
        chk("t1_code2", int'(d_code[0]), 2);
        step(8'h00, 8'hFF, 1'b1);
        chk("t1_idle", int'(d_valid[0]), 0);
        chk("t1_pending", int'(d_pend[0]), 0);
        drain();

        // Backpressure: held code must not be retracted by a higher request
        step(8'h01, 8'hFF, 1'b0);
        step(8'h80, 8'hFF, 1'b0);
        chk("t2_hold", int'(d_code[0]), 0);
        step(8'h00, 8'h00, 1'b0);
        chk("t2_hold_masked", int'(d_code[0]), 0);
        step(8'h00, 8'hFF, 1'b1);
        chk("t2_code7", int'(d_code[0]), 7);
        step(8'h00, 8'hFF, 1'b1);
        chk("t2_idle", int'(d_valid[0]), 0);
        drain();

        // Mask limits selection; masked lines stay pending
        step(8'hFF, 8'h0F, 1'b1);
        chk("t3_code3", int'(d_code[0]), 3);
        for (int k = 0; k < 4; k++) step(8'h00, 8'h0F, 1'b1);
        chk("t3_idle", int'(d_valid[0]), 0);
        chk("t3_pending", int'(d_pend[0]), 8'hF0);
        step(8'h00, 8'hFF, 1'b1);
        chk("t3_code7", int'(d_code[0]), 7);
        drain();

        // Set beats clear on the acknowledged line
        step(8'h10, 8'hFF, 1'b0);
        step(8'h10, 8'hFF, 1'b1);
        chk("t4_valid", int'(d_valid[0]), 1);
        chk("t4_code", int'(d_code[0]), 4);
        chk("t4_pending", int'(d_pend[0]), 8'h10);
        drain();

        // Ready while idle clears nothing
        step(8'h00, 8'hFF, 1'b1);
        chk("idle_ready", int'(d_valid[0]), 0);

        for (int n = 0; n < 800; n++)
            step(8'($urandom & $urandom & $urandom),
                 ($urandom_range(3) == 0) ? 8'($urandom) : 8'hFF,
                 1'($urandom_range(2) != 0));

        // Async reset in the middle of a hold, between clock edges
        step(8'h3C, 8'hFF, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("arst_valid", int'(d_valid[i]), 0);
            chk("arst_code", int'(d_code[i]), 0);
            chk("arst_pending", int'(d_pend[i]), 0);
        end
        model_reset();
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int n = 0; n < 800; n++)
            step(8'($urandom & $urandom),
                 ($urandom_range(3) == 0) ? 8'($urandom) : 8'hFF,
                 1'($urandom_range(3) != 0));
        drain();

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain actual=%0d required=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
